// File: rtl/remote_comm.sv
// Ground-side end of the copter command link: sends {cmd, data} as three 8N1 bytes,
// then waits for a one-byte reply from the copter or gives up after TIMEOUT_CYC clocks.
module remote_comm #(
   parameter int BAUD_DIV    = 2604,
   parameter int TIMEOUT_CYC = 5_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd_cmd,
   input  logic [7:0]  cmd,
   input  logic [15:0] data,
   input  logic        RX,
   output logic        TX,
   output logic        busy,
   output logic        cmd_sent,
   output logic        resp_rdy,
   output logic [7:0]  resp,
   output logic        timeout
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_MID  = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_TX_CMD, S_TX_DHI, S_TX_DLO, S_WAIT_RESP} state_e;
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

   state_e          state_q, state_d;
   logic [15:0]     data_q, data_d;
   logic [9:0]      tx_sh_q, tx_sh_d;
   logic [BW-1:0]   tx_baud_q, tx_baud_d;
   logic [3:0]      tx_bit_q, tx_bit_d;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
   logic [7:0]      resp_q, resp_d;
   logic            cmd_sent_q, cmd_sent_d;
   logic            resp_rdy_q, resp_rdy_d;
   logic            timeout_q, timeout_d;

   rx_state_e       rx_state_q, rx_state_d;
   logic [BW-1:0]   rx_baud_q, rx_baud_d;
   logic [3:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_sh_q, rx_sh_d;
   logic            rx_s1_q, rx_s2_q, rx_s3_q;
   logic            rx_ok;

   assign tmo_inc = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_ok      = 1'b0;
      unique case (rx_state_q)
         R_IDLE: if (rx_s3_q && !rx_s2_q) begin
            rx_state_d = R_START;
            rx_baud_d  = '0;
         end
         R_START: if (rx_baud_q == BAUD_MID) begin
            rx_baud_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
         end else rx_baud_d = rx_baud_q + 1'b1;
         R_DATA: if (rx_baud_q == BAUD_LAST) begin
            rx_baud_d = '0;
            rx_sh_d   = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d  = rx_bit_q + 4'd1;
            if (rx_bit_q == 4'd7) rx_state_d = R_STOP;
         end else rx_baud_d = rx_baud_q + 1'b1;
         R_STOP: if (rx_baud_q == BAUD_LAST) begin
            rx_baud_d  = '0;
            rx_state_d = R_IDLE;
            rx_ok      = rx_s2_q;
         end else rx_baud_d = rx_baud_q + 1'b1;
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      tx_sh_d    = tx_sh_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tmo_cnt_d  = tmo_cnt_q;
      resp_d     = resp_q;
      cmd_sent_d = 1'b0;
      resp_rdy_d = 1'b0;
      timeout_d  = 1'b0;
      unique case (state_q)
         S_IDLE: if (snd_cmd) begin
            state_d   = S_TX_CMD;
            data_d    = data;
            tx_sh_d   = {1'b1, cmd, 1'b0};
            tx_baud_d = '0;
            tx_bit_d  = '0;
         end
         S_TX_CMD, S_TX_DHI, S_TX_DLO: begin
            if (tx_baud_q != BAUD_LAST) begin
               tx_baud_d = tx_baud_q + 1'b1;
            end else begin
               tx_baud_d = '0;
               if (tx_bit_q != 4'd9) begin
                  tx_bit_d = tx_bit_q + 4'd1;
                  tx_sh_d  = {1'b1, tx_sh_q[9:1]};
               end else begin
                  // Stop bit done: next byte starts immediately with its start bit.
                  tx_bit_d = '0;
                  if (state_q == S_TX_CMD) begin
                     state_d = S_TX_DHI;
                     tx_sh_d = {1'b1, data_q[15:8], 1'b0};
                  end else if (state_q == S_TX_DHI) begin
                     state_d = S_TX_DLO;
                     tx_sh_d = {1'b1, data_q[7:0], 1'b0};
                  end else begin
                     state_d    = S_WAIT_RESP;
                     tx_sh_d    = '1;
                     cmd_sent_d = 1'b1;
                     tmo_cnt_d  = '0;
                  end
               end
            end
         end
         S_WAIT_RESP: begin
            tmo_cnt_d = tmo_inc;
            if (rx_ok) begin
               resp_d     = rx_sh_q;
               resp_rdy_d = 1'b1;
               state_d    = S_IDLE;
            end else if (tmo_inc == TMO_MAX) begin
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: synchronizer and TX shifter reset to 1 so the idle line never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         data_q     <= '0;
         tx_sh_q    <= '1;
         tx_baud_q  <= '0;
         tx_bit_q   <= '0;
         tmo_cnt_q  <= '0;
         resp_q     <= '0;
         cmd_sent_q <= 1'b0;
         resp_rdy_q <= 1'b0;
         timeout_q  <= 1'b0;
         rx_state_q <= R_IDLE;
         rx_baud_q  <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_s3_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         tx_sh_q    <= tx_sh_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tmo_cnt_q  <= tmo_cnt_d;
         resp_q     <= resp_d;
         cmd_sent_q <= cmd_sent_d;
         resp_rdy_q <= resp_rdy_d;
         timeout_q  <= timeout_d;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_s1_q    <= RX;
         rx_s2_q    <= rx_s1_q;
         rx_s3_q    <= rx_s2_q;
      end
   end

   assign TX       = tx_sh_q[0];
   assign busy     = (state_q != S_IDLE);
   assign cmd_sent = cmd_sent_q;
   assign resp_rdy = resp_rdy_q;
   assign resp     = resp_q;
   assign timeout  = timeout_q;
endmodule
